relay_cycle_sequencer: RTL

Master timing sequencer for the relay computer. Produces the one-hot 24-bit state vector that drives the instruction decode logic, where bit k-1 means state_k. It counts fetch cycles 1-3 and then the instruction's execute cycles, with the instruction length decoded from the instruction register at state 4. It also handles run/stop, single-step and HALT.

---
 rtl/relay_pkg.sv | 34 +++
 rtl/relay_inst_length.sv | 42 ++++
 rtl/relay_cycle_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/relay_pkg.sv
// Shared types and constants for the relay computer timing sequencer and its decode logic.
// Holds controller states, opcode match patterns, instruction lengths and the state_k one-hot codes.
package relay_pkg;

  localparam int NUM_STATES = 24;
  localparam int LEN_SHORT  = 8;
  localparam int LEN_MOV16  = 10;
  localparam int LEN_MEM    = 12;
  localparam int LEN_INC    = 14;
  localparam int LEN_LONG   = 24;

  typedef enum logic [1:0] {IDLE, SEQ, PAUSE, HALTED} seq_state_e;
  typedef logic [23:0] fsm_onehot_t;

  // Opcode classes: an opcode belongs to a class when (op & MASK) == VAL.
  localparam logic [7:0] OP_MOV8_MASK  = 8'hC0, OP_MOV8_VAL  = 8'h00;
  localparam logic [7:0] OP_SETAB_MASK = 8'hC0, OP_SETAB_VAL = 8'h40;
  localparam logic [7:0] OP_ALU_MASK   = 8'hF0, OP_ALU_VAL   = 8'h80;
  localparam logic [7:0] OP_MEM_MASK   = 8'hF0, OP_MEM_VAL   = 8'h90;
  localparam logic [7:0] OP_MOV16_MASK = 8'hF0, OP_MOV16_VAL = 8'hA0;
  localparam logic [7:0] OP_INCXY_MASK = 8'hFF, OP_INCXY_VAL = 8'hB0;
  localparam logic [7:0] OP_HALT_MASK  = 8'hF8, OP_HALT_VAL  = 8'hB8;
  localparam logic [7:0] OP_LONG_MASK  = 8'hC0, OP_LONG_VAL  = 8'hC0;

  localparam fsm_onehot_t state_1  = 24'h000001, state_2  = 24'h000002, state_3  = 24'h000004;
  localparam fsm_onehot_t state_4  = 24'h000008, state_5  = 24'h000010, state_6  = 24'h000020;
  localparam fsm_onehot_t state_7  = 24'h000040, state_8  = 24'h000080, state_9  = 24'h000100;
  localparam fsm_onehot_t state_10 = 24'h000200, state_11 = 24'h000400, state_12 = 24'h000800;
  localparam fsm_onehot_t state_13 = 24'h001000, state_14 = 24'h002000, state_15 = 24'h004000;
  localparam fsm_onehot_t state_16 = 24'h008000, state_17 = 24'h010000, state_18 = 24'h020000;
  localparam fsm_onehot_t state_19 = 24'h040000, state_20 = 24'h080000, state_21 = 24'h100000;
  localparam fsm_onehot_t state_22 = 24'h200000, state_23 = 24'h400000, state_24 = 24'h800000;

endpackage

// File: rtl/relay_inst_length.sv
// Opcode -> instruction length decoder, purely combinational (zero latency, no flow control).
// First-match priority; unassigned 1011xxxx codes run as short no-ops and are flagged illegal.
module relay_inst_length
  import relay_pkg::*;
#(
  parameter int LEN_SHORT = relay_pkg::LEN_SHORT,
  parameter int LEN_MOV16 = relay_pkg::LEN_MOV16,
  parameter int LEN_MEM   = relay_pkg::LEN_MEM,
  parameter int LEN_INC   = relay_pkg::LEN_INC,
  parameter int LEN_LONG  = relay_pkg::LEN_LONG
) (
  input  logic [7:0] opcode,
  output logic [4:0] len,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    len        = 5'(LEN_SHORT);
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (((opcode & OP_MOV8_MASK) == OP_MOV8_VAL) ||
        ((opcode & OP_SETAB_MASK) == OP_SETAB_VAL) ||
        ((opcode & OP_ALU_MASK) == OP_ALU_VAL)) begin
      len = 5'(LEN_SHORT);
    end else if ((opcode & OP_MEM_MASK) == OP_MEM_VAL) begin
      len = 5'(LEN_MEM);
    end else if ((opcode & OP_MOV16_MASK) == OP_MOV16_VAL) begin
      len = 5'(LEN_MOV16);
    end else if ((opcode & OP_INCXY_MASK) == OP_INCXY_VAL) begin
      len = 5'(LEN_INC);
    end else if ((opcode & OP_HALT_MASK) == OP_HALT_VAL) begin
      len     = 5'(LEN_MOV16);
      is_halt = 1'b1;
    end else if ((opcode & OP_LONG_MASK) == OP_LONG_VAL) begin
      len = 5'(LEN_LONG);
    end else begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/relay_cycle_sequencer.sv
// Master one-hot cycle sequencer: starts state_1 one clock after run, length latched at state 4.
// No backpressure; run/step_mode only take effect at instruction boundaries, HALT exits only by reset.
module relay_cycle_sequencer
  import relay_pkg::*;
#(
  parameter int NUM_STATES = relay_pkg::NUM_STATES,
  parameter int LEN_SHORT  = relay_pkg::LEN_SHORT,
  parameter int LEN_MOV16  = relay_pkg::LEN_MOV16,
  parameter int LEN_MEM    = relay_pkg::LEN_MEM,
  parameter int LEN_INC    = relay_pkg::LEN_INC,
  parameter int LEN_LONG   = relay_pkg::LEN_LONG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step_mode,
  input  logic                  step_req,
  input  logic [7:0]            inst_reg_value,
  output logic [NUM_STATES-1:0] input_from_fsm,
  output logic [4:0]            cycle_num,
  output logic                  running,
  output logic                  halted,
  output logic                  inst_done,
  output logic                  illegal_op
);

  // Fetch cycles 1-3 are unconditional, so every length must cover them and fit the vector.
  if (NUM_STATES > 31 || LEN_SHORT < 4 || LEN_MOV16 < 4 || LEN_MEM < 4 || LEN_INC < 4 ||
      LEN_LONG < 4 || LEN_SHORT > NUM_STATES || LEN_MOV16 > NUM_STATES ||
      LEN_MEM > NUM_STATES || LEN_INC > NUM_STATES || LEN_LONG > NUM_STATES) begin : g_bad_len
    $error("relay_cycle_sequencer: instruction lengths must lie in 4..NUM_STATES");
  end

  localparam logic [NUM_STATES-1:0] VEC_FIRST = NUM_STATES'(1);

  seq_state_e            st_q;
  logic [4:0]            cyc_q;
  logic [4:0]            len_q;
  logic                  halt_q;
  logic [NUM_STATES-1:0] vec_q;
  logic                  running_q;
  logic                  halted_q;

  logic [4:0] dec_len;
  logic       dec_halt;
  logic       dec_illegal;

  relay_inst_length #(
    .LEN_SHORT (LEN_SHORT),
    .LEN_MOV16 (LEN_MOV16),
    .LEN_MEM   (LEN_MEM),
    .LEN_INC   (LEN_INC),
    .LEN_LONG  (LEN_LONG)
  ) u_len (
    .opcode     (inst_reg_value),
    .len        (dec_len),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  // At state 4 the fresh decode is used directly so a 4-cycle instruction still ends on time.
  logic       at_state4;
  logic [4:0] eff_len;
  logic       eff_halt;
  logic       last_cyc;

  assign at_state4 = (st_q == SEQ) && (cyc_q == 5'd4);
  assign eff_len   = at_state4 ? dec_len : len_q;
  assign eff_halt  = at_state4 ? dec_halt : halt_q;
  assign last_cyc  = (st_q == SEQ) && (cyc_q == eff_len);

  assign input_from_fsm = vec_q;
  assign cycle_num      = cyc_q;
  assign running        = running_q;
  assign halted         = halted_q;
  assign inst_done      = last_cyc;
  assign illegal_op     = at_state4 && dec_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      cyc_q     <= 5'd0;
      len_q     <= 5'(LEN_SHORT);
      halt_q    <= 1'b0;
      vec_q     <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (run) begin
            st_q      <= SEQ;
            cyc_q     <= 5'd1;
            vec_q     <= VEC_FIRST;
            running_q <= 1'b1;
          end
        end
        SEQ: begin
          if (at_state4) begin
            len_q  <= dec_len;
            halt_q <= dec_halt;
          end
          if (last_cyc) begin
            if (eff_halt || !run || step_mode) begin
              st_q      <= eff_halt ? HALTED : (!run ? IDLE : PAUSE);
              cyc_q     <= 5'd0;
              vec_q     <= '0;
              running_q <= 1'b0;
              halted_q  <= eff_halt;
            end else begin
              cyc_q <= 5'd1;
              vec_q <= VEC_FIRST;
            end
          end else begin
            cyc_q <= cyc_q + 5'd1;
            vec_q <= vec_q << 1;
          end
        end
        PAUSE: begin
          if (!run) begin
            st_q <= IDLE;
          end else if (!step_mode || step_req) begin
            st_q      <= SEQ;
            cyc_q     <= 5'd1;
            vec_q     <= VEC_FIRST;
            running_q <= 1'b1;
          end
        end
        HALTED: begin
          st_q <= HALTED;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule
